exec_mem_unit: RTL and testbench
================================

EXEC_MEM_UNIT -- requirements
Module: exec_mem_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named clk and reset.
REQ-002 Parameter MEM_DEPTH, default 256, SHALL set the number of 32-bit data-memory words.
REQ-003 Parameter ADDR_LSB, default 2, SHALL set the lowest byte-address bit used as the word index.
REQ-004 clk  input  1  rising-edge clock for data-memory writes.
REQ-005 reset  input  1  asynchronous active-high clear of data memory.
REQ-006 alu_a  input  32  ALU operand A (register rs value).
REQ-007 alu_b  input  32  ALU operand B (rt value or sign-extended immediate, selected upstream).
REQ-008 alu_control  input  4  ALU operation select.
REQ-009 alu_result  output  32  ALU result; also the data-memory byte address.
REQ-010 zero  output  1  1 when alu_result == 0.
REQ-011 pc  input  32  current program counter.
REQ-012 sign_imm  input  32  sign-extended 16-bit immediate.
REQ-013 pc_plus4  output  32  pc + 4.
REQ-014 pc_branch  output  32  branch target.
REQ-015 mem_write  input  1  data-memory write enable.
REQ-016 write_data  input  32  store data (rt value).
REQ-017 read_data  output  32  load data.

Function
REQ-018 ALU SHALL be combinational: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB (a-b), 0111 SLT (signed a<b -> 1 else 0), 1100 NOR; all other codes SHALL yield 0.
REQ-019 ADD/SUB SHALL be 32-bit modulo, no overflow flag or trap; carry-out discarded.
REQ-020 SLT SHALL compare as two's-complement signed values, correct across sign boundaries (0x80000000 < 0x7FFFFFFF).
REQ-021 zero SHALL be combinational from alu_result for every operation, including unsupported codes (zero=1).
REQ-022 pc_plus4 SHALL equal pc + 32'd4 modulo 2^32 (0xFFFFFFFC wraps to 0).
REQ-023 pc_branch SHALL equal pc_plus4 + (sign_imm << 2) modulo 2^32; bits shifted out of bit 31 are discarded.
REQ-024 Word index SHALL be alu_result[ADDR_LSB +: log2(MEM_DEPTH)]; bits below ADDR_LSB and above the index SHALL be ignored (addresses alias modulo 1 KiB).
REQ-025 read_data SHALL be combinational (asynchronous read) of the indexed word, zero-latency.
REQ-026 When mem_write=1 at a rising clk edge and reset=0, the indexed word SHALL take write_data; visible on read_data immediately after that edge.
REQ-027 A same-cycle read of the address being written SHALL return the old word before the edge and the new word after it.
REQ-028 mem_write=0 SHALL leave memory unchanged; no other write path exists.

Reset
REQ-029 reset=1 SHALL clear every memory word to 0 immediately, independent of clk.
REQ-030 reset SHALL take priority over a simultaneous write; the write is lost.
REQ-031 ALU and adder outputs SHALL be unaffected by reset (purely combinational); read_data SHALL read 0 during and after reset until written.

Structure
REQ-032 ALU opcode constants (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR) SHALL live in shared package mips_pkg, reused by the control unit.
REQ-033 The ALU SHALL be one sub-module, alu_core; adders and memory SHALL be inline.

Verification
REQ-034 alu_a=5, alu_b=3: control 0010 -> 8, zero=0; 0110 -> 2; 0110 with a=b=7 -> 0, zero=1.
REQ-035 alu_a=0xFFFFFFFF, alu_b=1: 0111 -> 1; 0010 -> 0, zero=1; 1100 with a=0,b=0 -> 0xFFFFFFFF; code 1111 -> 0.
REQ-036 pc=0x00000010, sign_imm=0xFFFFFFFE -> pc_plus4=0x14, pc_branch=0x0C; pc=0xFFFFFFFC -> pc_plus4=0.
REQ-037 Store 0xDEADBEEF at address 0x8 (mem_write=1, one edge) -> read_data=0xDEADBEEF at address 0x8 and 0x408; address 0xC reads 0.
REQ-038 After store, assert reset mid-cycle with mem_write=1 -> read_data=0 immediately and stays 0 after the next edge.
REQ-039 mem_write=0 across several edges with changing write_data -> stored word unchanged.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions.
// Holds the 4-bit ALU operation codes used by the control unit and the ALU.
package mips_pkg;

  localparam int unsigned AluCtrlW = 4;

  localparam logic [AluCtrlW-1:0] ALU_AND = 4'b0000;
  localparam logic [AluCtrlW-1:0] ALU_OR  = 4'b0001;
  localparam logic [AluCtrlW-1:0] ALU_ADD = 4'b0010;
  localparam logic [AluCtrlW-1:0] ALU_SUB = 4'b0110;
  localparam logic [AluCtrlW-1:0] ALU_SLT = 4'b0111;
  localparam logic [AluCtrlW-1:0] ALU_NOR = 4'b1100;

endpackage

// File: rtl/alu_core.sv
// Combinational 32-bit MIPS ALU.
// Ports:
//   a, b         : operands
//   alu_control  : operation select (codes from mips_pkg)
//   result       : operation result; unsupported codes give 0
//   zero         : 1 when result == 0
module alu_core
  import mips_pkg::*;
(
  input  logic [31:0]         a,
  input  logic [31:0]         b,
  input  logic [AluCtrlW-1:0] alu_control,
  output logic [31:0]         result,
  output logic                zero
);

  always_comb begin
    result = '0;
    case (alu_control)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      // ADD/SUB wrap modulo 2^32; carry-out is simply dropped
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_SLT: result = {31'd0, ($signed(a) < $signed(b))};
      ALU_NOR: result = ~(a | b);
      default: result = '0;
    endcase
  end

  assign zero = (result == 32'd0);

endmodule

// File: rtl/exec_mem_unit.sv
// Execute + memory stage of a single-cycle MIPS datapath.
// ALU, PC adders and a word-addressed data memory with asynchronous read.
// Ports:
//   clk, reset     : write clock; async active-high reset clears memory
//   alu_a, alu_b   : ALU operands
//   alu_control    : ALU operation select
//   alu_result     : ALU result, also the data-memory byte address
//   zero           : alu_result == 0
//   pc, sign_imm   : current PC and sign-extended immediate
//   pc_plus4       : pc + 4
//   pc_branch      : pc_plus4 + (sign_imm << 2)
//   mem_write      : data-memory write enable
//   write_data     : store data
//   read_data      : load data (combinational)
module exec_mem_unit
  import mips_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned ADDR_LSB  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         alu_a,
  input  logic [31:0]         alu_b,
  input  logic [AluCtrlW-1:0] alu_control,
  output logic [31:0]         alu_result,
  output logic                zero,
  input  logic [31:0]         pc,
  input  logic [31:0]         sign_imm,
  output logic [31:0]         pc_plus4,
  output logic [31:0]         pc_branch,
  input  logic                mem_write,
  input  logic [31:0]         write_data,
  output logic [31:0]         read_data
);

  localparam int unsigned IdxW = $clog2(MEM_DEPTH);

  alu_core u_alu_core (
    .a          (alu_a),
    .b          (alu_b),
    .alu_control(alu_control),
    .result     (alu_result),
    .zero       (zero)
  );

  // Bits shifted past bit 31 of the immediate are intentionally lost.
  assign pc_plus4  = pc + 32'd4;
  assign pc_branch = pc_plus4 + (sign_imm << 2);

  // Byte-offset bits and bits above the index are ignored, so addresses alias.
  logic [IdxW-1:0] mem_idx;
  assign mem_idx = alu_result[ADDR_LSB +: IdxW];

  logic [31:0] mem_q [MEM_DEPTH];

  // Reset wins over a simultaneous write; the write is discarded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(MEM_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_write) begin
      mem_q[mem_idx] <= write_data;
    end
  end

  assign read_data = mem_q[mem_idx];

endmodule

// File: tb/tb_exec_mem_unit.sv
// Scoreboard bench for exec_mem_unit: stimulus pushes expected values,
// a monitor on the falling clock edge pops and compares them.
module tb_exec_mem_unit;
  import mips_pkg::*;

  localparam int SelRes  = 0;
  localparam int SelZero = 1;
  localparam int SelPc4  = 2;
  localparam int SelBr   = 3;
  localparam int SelRd   = 4;

  logic        clk;
  logic        reset;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_control;
  logic [31:0] alu_result;
  logic        zero;
  logic [31:0] pc, sign_imm, pc_plus4, pc_branch;
  logic        mem_write;
  logic [31:0] write_data, read_data;

  int tests_run;
  int tests_failed;

  string       name_q[$];
  int          sel_q[$];
  logic [31:0] exp_q[$];

  exec_mem_unit #(
    .MEM_DEPTH(256),
    .ADDR_LSB (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_control(alu_control),
    .alu_result (alu_result),
    .zero       (zero),
    .pc         (pc),
    .sign_imm   (sign_imm),
    .pc_plus4   (pc_plus4),
    .pc_branch  (pc_branch),
    .mem_write  (mem_write),
    .write_data (write_data),
    .read_data  (read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_val(input string name, input int sel, input logic [31:0] val);
    name_q.push_back(name);
    sel_q.push_back(sel);
    exp_q.push_back(val);
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every queued expectation against the settled outputs.
  initial begin
    string       nm;
    int          sel;
    logic [31:0] ev;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (name_q.size() > 0) begin
        nm  = name_q.pop_front();
        sel = sel_q.pop_front();
        ev  = exp_q.pop_front();
        case (sel)
          SelRes:  act = alu_result;
          SelZero: act = {31'd0, zero};
          SelPc4:  act = pc_plus4;
          SelBr:   act = pc_branch;
          default: act = read_data;
        endcase
        tests_run++;
        if (act !== ev) begin
          tests_failed++;
          $display("FAIL %s: got %h expected %h", nm, act, ev);
        end
      end
    end
  end

  initial begin
    int waited;
    tests_run    = 0;
    tests_failed = 0;
    reset       = 1'b1;
    alu_a       = 32'd5;
    alu_b       = 32'd3;
    alu_control = ALU_ADD;
    pc          = 32'h0000_0010;
    sign_imm    = 32'hFFFF_FFFE;
    mem_write   = 1'b0;
    write_data  = '0;

    // Reset: memory reads 0, ALU and adders still live.
    step();
    expect_val("rst_add_res", SelRes, 32'd8);
    expect_val("rst_add_zero", SelZero, 32'd0);
    expect_val("rst_rd", SelRd, 32'd0);
    expect_val("pc_plus4", SelPc4, 32'h14);
    expect_val("pc_branch_neg", SelBr, 32'h0C);

    step();
    reset = 1'b0;
    alu_control = ALU_SUB;
    expect_val("sub_5_3", SelRes, 32'd2);
    expect_val("sub_5_3_zero", SelZero, 32'd0);

    step();
    alu_a = 32'd7; alu_b = 32'd7;
    expect_val("sub_eq", SelRes, 32'd0);
    expect_val("sub_eq_zero", SelZero, 32'd1);

    step();
    alu_a = 32'hFFFF_FFFF; alu_b = 32'd1; alu_control = ALU_SLT;
    pc = 32'hFFFF_FFFC; sign_imm = 32'd0;
    expect_val("slt_m1_1", SelRes, 32'd1);
    expect_val("pc4_wrap", SelPc4, 32'd0);
    expect_val("br_wrap", SelBr, 32'd0);

    step();
    alu_control = ALU_ADD;
    pc = 32'd0; sign_imm = 32'h4000_0001;
    expect_val("add_wrap", SelRes, 32'd0);
    expect_val("add_wrap_zero", SelZero, 32'd1);
    expect_val("br_shift_out", SelBr, 32'd8);

    step();
    alu_a = 32'd0; alu_b = 32'd0; alu_control = ALU_NOR;
    expect_val("nor_0_0", SelRes, 32'hFFFF_FFFF);

    step();
    alu_control = 4'b1111;
    alu_a = 32'h1234; alu_b = 32'h5678;
    expect_val("bad_op", SelRes, 32'd0);
    expect_val("bad_op_zero", SelZero, 32'd1);

    step();
    alu_a = 32'h0000_F0F0; alu_b = 32'h0000_FF00; alu_control = ALU_AND;
    expect_val("and", SelRes, 32'h0000_F000);

    step();
    alu_control = ALU_OR;
    expect_val("or", SelRes, 32'h0000_FFF0);

    step();
    alu_a = 32'h8000_0000; alu_b = 32'h7FFF_FFFF; alu_control = ALU_SLT;
    expect_val("slt_min_max", SelRes, 32'd1);

    step();
    alu_a = 32'h7FFF_FFFF; alu_b = 32'h8000_0000;
    expect_val("slt_max_min", SelRes, 32'd0);

    // Store 0xDEADBEEF at byte address 8; old word visible before the edge.
    step();
    alu_a = 32'd8; alu_b = 32'd0; alu_control = ALU_ADD;
    mem_write = 1'b1; write_data = 32'hDEAD_BEEF;
    expect_val("st_before_edge", SelRd, 32'd0);

    step();
    mem_write = 1'b0;
    expect_val("ld_8", SelRd, 32'hDEAD_BEEF);

    step();
    alu_a = 32'h408;
    expect_val("ld_alias_408", SelRd, 32'hDEAD_BEEF);

    step();
    alu_a = 32'hC;
    expect_val("ld_c", SelRd, 32'd0);

    step();
    alu_a = 32'hB;
    expect_val("ld_b_lowbits", SelRd, 32'hDEAD_BEEF);

    // No write when mem_write is low, whatever write_data does.
    for (int i = 0; i < 3; i++) begin
      step();
      alu_a = 32'd8;
      write_data = 32'h1111_0000 + 32'(i);
      expect_val("hold", SelRd, 32'hDEAD_BEEF);
    end

    // Reset mid-cycle with a pending write.
    step();
    mem_write = 1'b1; write_data = 32'h1234_5678;
    reset = 1'b1;
    expect_val("rst_mid_rd", SelRd, 32'd0);
    expect_val("rst_mid_res", SelRes, 32'd8);

    step();
    expect_val("rst_vs_wr", SelRd, 32'd0);

    step();
    reset = 1'b0; mem_write = 1'b0;
    expect_val("post_rst", SelRd, 32'd0);

    step();
    mem_write = 1'b1;
    expect_val("wr2_before", SelRd, 32'd0);

    step();
    mem_write = 1'b0;
    expect_val("wr2_after", SelRd, 32'h1234_5678);

    // Bounded drain of the scoreboard.
    waited = 0;
    while (name_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    if (name_q.size() > 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL drain: got %0d pending expected 0", name_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
